lfsr_rng: RTL and testbench
===========================

// Module: lfsr_rng
// PURPOSE
//  Parametrised Galois LFSR pseudo-random source for game logic (ball launch angle, serve side, speed jitter).
//  Generalises the fixed 9-bit LFSR:
//   - width and tap mask are parameters
//   - explicit clear and seed-load
//   - manual step input
//   - step strobe output
//   - zero-lockup protection
//   - optional range-scaled output
//  Sits between the game-state FSM (drives clear/enable) and the ball/paddle logic (consumes o_reg/o_Range).
// PARAMETERS
//  WIDTH        9        LFSR width in bits (>=3)
//  TAPS         9'h010   Galois feedback mask; TAPS[i]=1 XORs feedback into bit i (i=1..WIDTH-1); TAPS[0] ignored
//  INIT_VAL     9'h1AE   value after reset/clear; must be nonzero (zero is replaced by 1)
//  DELAY_COUNT  10000000 auto-step period minus one, in clocks; 0 = step every enabled cycle
//  RANGE        6        output range for o_Range, values 0..RANGE-1 (used only with LFSR_RANGE_EN)
// PORTS
//  i_Clk       in   1              system clock, all logic rising-edge
//  i_Rst_n     in   1              asynchronous active-low reset
//  i_Clear     in   1              sync restart: register<=INIT_VAL, counter reloaded
//  i_Enable    in   1              allows auto and manual stepping
//  i_Step      in   1              force one step this cycle (when enabled)
//  i_Load      in   1              sync seed load strobe
//  i_Load_Val  in   WIDTH          seed value for i_Load
//  o_reg       out  WIDTH          current LFSR state
//  o_Step      out  1              1-cycle pulse, high in cycle o_reg shows a newly stepped value
//  o_Range     out  clog2(RANGE)   scaled random value (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, i_Rst_n=0):
//   - r_reg=INIT_VAL (1 if INIT_VAL==0); counter=DELAY_COUNT; o_Step=0; o_Range=0.
//  Per-clock priority: i_Clear > i_Load > step > hold.
//   - Clear: r_reg<=INIT_VAL; counter<=DELAY_COUNT; o_Step<=0. Ignores i_Enable.
//   - Load: r_reg<=i_Load_Val, or INIT_VAL if i_Load_Val==0 (zero-lockup guard); counter<=DELAY_COUNT; o_Step<=0.
//   - Step condition: i_Enable && (counter==0 || i_Step).
//       new[0] = r[W-1]
//       new[i] = TAPS[i] ? r[i-1]^r[W-1] : r[i-1], for i=1..W-1
//     On step: counter<=DELAY_COUNT; o_Step<=1 (registered, coincides with new o_reg).
//   - Enabled, no step: counter decrements by 1; o_Step<=0.
//   - i_Enable=0, no clear/load: r_reg and counter hold; o_Step<=0.
//  Auto-step period is DELAY_COUNT+1 enabled cycles.
//   - i_Step on the same cycle as counter==0 gives one step only.
//   - i_Step restarts the full period.
//  Counter width: clog2(DELAY_COUNT+1), min 1. No wrap below 0: reload occurs at 0.
//  r_reg never reaches zero: the shift is invertible for nonzero states; zero can only enter via load, which is guarded.
//  Reset asserted mid-period: immediate, no pending step survives.
// CONFIGURATION
//  Macro LFSR_RANGE_EN:
//   - defined: o_Range <= (r_reg*RANGE)>>WIDTH, registered.
//       Updates one cycle after o_reg changes (latency 1).
//       Value always in 0..RANGE-1. Reset/clear drive 0, then track normally.
//   - undefined: o_Range tied to 0; no multiplier is synthesised.
// TESTING
//  1. Reset with INIT_VAL=9'h001, DELAY_COUNT=0, enable=1 -> o_reg 002,004,...,100 on steps 1-8; step 9 = 9'h011; o_Step high every cycle.
//  2. DELAY_COUNT=3, enable=1 from reset -> o_Step pulses every 4th clock; o_reg constant in between.
//  3. i_Load=1, i_Load_Val=0 -> o_reg=INIT_VAL next cycle. i_Load_Val=9'h0AB -> o_reg=9'h0AB, counter reloaded.
//  4. i_Clear and i_Load same cycle -> o_reg=INIT_VAL. i_Step while i_Enable=0 -> no change, o_Step=0.
//  5. Full period, WIDTH=9 with a maximal TAPS -> state returns to seed after exactly 511 steps, never 0.
//  6. LFSR_RANGE_EN, RANGE=6, o_reg=9'h1FF -> o_Range=5 one cycle later. o_reg=9'h001 -> o_Range=0.

Source files
------------

// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Galois LFSR random source with clear, seed load, manual step and zero-lockup guard.
// Define LFSR_RANGE_EN to build the registered range-scaled output o_Range; otherwise o_Range is tied to 0.
module lfsr_rng #(
  parameter int WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS = 9'h010,
  parameter logic [WIDTH-1:0] INIT_VAL = 9'h1AE,
  parameter int DELAY_COUNT = 10000000,
  parameter int RANGE = 6,
  localparam int RW = RANGE > 1 ? $clog2(RANGE) : 1
)(
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic             i_Step,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic [WIDTH-1:0] o_reg,
  output logic             o_Step,
  output logic [RW-1:0]    o_Range
);
  localparam logic [WIDTH-1:0] SEED = (INIT_VAL == '0) ? WIDTH'(1) : INIT_VAL;
  localparam int CW = DELAY_COUNT > 0 ? $clog2(DELAY_COUNT + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DELAY_COUNT);
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] reg_nxt, shifted;
  logic step;
  always_comb begin
    step = i_Enable && (cnt == '0 || i_Step);
    shifted = {o_reg[WIDTH-2:0], 1'b0} ^ ({WIDTH{o_reg[WIDTH-1]}} & {TAPS[WIDTH-1:1], 1'b1});
    reg_nxt = i_Clear ? SEED : i_Load ? (i_Load_Val == '0 ? SEED : i_Load_Val) : step ? shifted : o_reg;
    cnt_nxt = (i_Clear || i_Load || step) ? RELOAD : i_Enable ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_reg  <= SEED;
      cnt    <= RELOAD;
      o_Step <= 1'b0;
    end else begin
      o_reg  <= reg_nxt;
      cnt    <= cnt_nxt;
      o_Step <= step && !i_Clear && !i_Load;
    end
  end
`ifdef LFSR_RANGE_EN
  // RANGE <= 2**RW, so WIDTH+RW bits hold the full product
  logic [WIDTH+RW-1:0] prod;
  assign prod = (WIDTH+RW)'(o_reg) * (WIDTH+RW)'(RANGE);
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) o_Range <= '0;
    else o_Range <= i_Clear ? '0 : RW'(prod >> WIDTH);
  end
`else
  assign o_Range = '0;
`endif
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: two lfsr_rng instances (DELAY_COUNT 0 and 3) checked every cycle against a polynomial model.
module tb_lfsr_rng;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clear = 1'b0, enable = 1'b1, step = 1'b0, load = 1'b0;
  logic [8:0] load_val = '0;
  logic [8:0] reg_a, reg_b;
  logic step_a, step_b;
  logic [2:0] rng_a, rng_b;
  int n_cmp = 0, n_bad = 0;
  int mreg[2], mcnt[2], mrng[2];
  bit mstp[2];
  int dc[2] = '{0, 3};
  int init[2] = '{1, 'h1AE};

  always #5 clk = ~clk;

  lfsr_rng #(.WIDTH(9), .TAPS(9'h010), .INIT_VAL(9'h001), .DELAY_COUNT(0), .RANGE(6)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clear), .i_Enable(enable), .i_Step(step),
    .i_Load(load), .i_Load_Val(load_val), .o_reg(reg_a), .o_Step(step_a), .o_Range(rng_a));
  lfsr_rng #(.WIDTH(9), .TAPS(9'h010), .INIT_VAL(9'h1AE), .DELAY_COUNT(3), .RANGE(6)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clear), .i_Enable(enable), .i_Step(step),
    .i_Load(load), .i_Load_Val(load_val), .o_reg(reg_b), .o_Step(step_b), .o_Range(rng_b));

  // multiply by x modulo x^9 + x^4 + 1
  function automatic int mulx(int r);
    int t = r << 1;
    if (t >= 512) t = t ^ 'h211;
    return t;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mreg[i] = init[i]; mcnt[i] = 0; mstp[i] = 0; mrng[i] = 0;
      end else begin
        mrng[i] = clear ? 0 : (mreg[i] * 6) / 512;
        if (clear) begin
          mreg[i] = init[i]; mcnt[i] = 0; mstp[i] = 0;
        end else if (load) begin
          mreg[i] = (load_val == 0) ? init[i] : int'(load_val); mcnt[i] = 0; mstp[i] = 0;
        end else if (enable && (mcnt[i] == dc[i] || step)) begin
          mreg[i] = mulx(mreg[i]); mcnt[i] = 0; mstp[i] = 1;
        end else begin
          if (enable) mcnt[i]++;
          mstp[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model reg_a", int'(reg_a), mreg[0]);
    chk("model reg_b", int'(reg_b), mreg[1]);
    chk("model step_a", int'(step_a), int'(mstp[0]));
    chk("model step_b", int'(step_b), int'(mstp[1]));
`ifdef LFSR_RANGE_EN
    chk("model rng_a", int'(rng_a), mrng[0]);
    chk("model rng_b", int'(rng_b), mrng[1]);
`else
    chk("rng_a tied", int'(rng_a), 0);
    chk("rng_b tied", int'(rng_b), 0);
`endif
  end

  initial begin
    int n;
    repeat (2) tick();
    chk("reset reg_a", int'(reg_a), 'h001);
    chk("reset reg_b", int'(reg_b), 'h1AE);
    chk("reset step_a", int'(step_a), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("seq reg_a", int'(reg_a), i == 9 ? 'h011 : (1 << i));
      chk("seq step_a", int'(step_a), 1);
      chk("period step_b", int'(step_b), (i % 4 == 0) ? 1 : 0);
    end
    load = 1'b1; load_val = 9'h000;
    tick();
    chk("load0 reg_a", int'(reg_a), 'h001);
    chk("load0 reg_b", int'(reg_b), 'h1AE);
    load_val = 9'h0AB;
    tick();
    chk("load reg_a", int'(reg_a), 'h0AB);
    chk("load reg_b", int'(reg_b), 'h0AB);
    chk("load step_b", int'(step_b), 0);
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) chk("after load reg_a", int'(reg_a), 'h156);
      chk("reload step_b", int'(step_b), i == 4 ? 1 : 0);
    end
    tick(); tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("restart step_b", int'(step_b), i == 4 ? 1 : 0);
    end
    clear = 1'b1; load = 1'b1; load_val = 9'h055;
    tick();
    chk("clear>load reg_a", int'(reg_a), 'h001);
    chk("clear>load reg_b", int'(reg_b), 'h1AE);
    load = 1'b0; enable = 1'b0;
    tick();
    clear = 1'b0; step = 1'b1;
    repeat (3) begin
      tick();
      chk("disabled reg_a", int'(reg_a), 'h001);
      chk("disabled step_a", int'(step_a), 0);
    end
    enable = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1 chk("async reg_b", int'(reg_b), 'h1AE);
    chk("async step_a", int'(step_a), 0);
    tick();
    rst_n = 1'b1;
    load = 1'b1; load_val = 9'h0AB;
    tick();
    load = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (reg_a == '0) chk("never zero", int'(reg_a), 1);
    end while (reg_a != 9'h0AB && n < 600);
    chk("full period", n, 511);
    enable = 1'b0; load = 1'b1; load_val = 9'h1FF;
    tick();
    load = 1'b0;
    tick();
`ifdef LFSR_RANGE_EN
    chk("range 1FF", int'(rng_a), 5);
`else
    chk("range off 1FF", int'(rng_a), 0);
`endif
    load = 1'b1; load_val = 9'h001;
    tick();
    load = 1'b0;
    tick();
    chk("range 001", int'(rng_a), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear rng_b", int'(rng_b), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
